// File: rtl/spi_sched_pkg.sv
// Shared types and defaults for the SPI transfer scheduler.
// rr_next picks the first requester after `last`, wrapping, out of n requesters.
package spi_sched_pkg;

  typedef enum logic [1:0] {IDLE, START, XFER, GAP} state_t;

  localparam int START_TO_DEF = 64;
  localparam int XFER_TO_DEF  = 512;
  localparam int GAP_DEF      = 16;

  function automatic logic [2:0] rr_next(input logic [2:0] last, input logic [7:0] req,
                                         input int unsigned n);
    logic [2:0]  idx;
    logic        found;
    int unsigned c;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= 8; k++) begin
      if (k <= n && !found) begin
        c = (32'(last) + k) % n;
        if (req[c[2:0]]) begin
          idx   = c[2:0];
          found = 1'b1;
        end
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick over req, searching from last+1 with wrap-around.
// Zero latency; grant is empty when en is low or nobody requests.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  input  logic             en,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    idx,
  output logic             vld
);
  import spi_sched_pkg::*;

  always_comb begin
    idx   = IW'(rr_next(3'(last), 8'(req), N_REQ));
    vld   = en && (|req);
    grant = vld ? (N_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/spi_xfer_sched.sv
// Shares one SPI master between N_REQ requesters: grant 1 cycle after req when idle,
// then start/transfer with timeouts and a fixed idle gap; requests wait while busy.
module spi_xfer_sched #(
  parameter int N_REQ    = 4,
  parameter int DW       = 8,
  parameter int START_TO = spi_sched_pkg::START_TO_DEF,
  parameter int XFER_TO  = spi_sched_pkg::XFER_TO_DEF,
  parameter int GAP      = spi_sched_pkg::GAP_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [N_REQ-1:0]    rsp_err,
  output logic [DW-1:0]       rsp_data,
  output logic                busy,
  output logic                m_start,
  output logic [DW-1:0]       m_din,
  input  logic                m_busy,
  input  logic                m_done,
  input  logic [DW-1:0]       m_dout
);
  import spi_sched_pkg::*;

  localparam int TMAX = (START_TO > XFER_TO) ? ((START_TO > GAP) ? START_TO : GAP)
                                             : ((XFER_TO > GAP) ? XFER_TO : GAP);
  localparam int TW = $clog2(TMAX) + 1;
  localparam int IW = $clog2(N_REQ);
  localparam logic [TW-1:0] START_LAST = TW'(START_TO - 1);
  localparam logic [TW-1:0] XFER_LAST  = TW'(XFER_TO - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP - 1);

  state_t           state;
  logic [TW-1:0]    timer;
  logic [IW-1:0]    owner;
  logic [IW-1:0]    last;
  logic [IW-1:0]    arb_idx;
  logic [N_REQ-1:0] arb_gnt;
  logic             arb_vld;

  rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
    .req   (req),
    .last  (last),
    .en    (state == IDLE),
    .grant (arb_gnt),
    .idx   (arb_idx),
    .vld   (arb_vld)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last      <= IW'(N_REQ - 1);
      owner     <= '0;
      timer     <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_err   <= '0;
      rsp_data  <= '0;
      busy      <= 1'b0;
      m_start   <= 1'b0;
      m_din     <= '0;
    end else begin
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_err   <= '0;
      case (state)
        IDLE: begin
          if (arb_vld) begin
            owner   <= arb_idx;
            last    <= arb_idx;
            m_din   <= req_data[arb_idx*DW +: DW];
            gnt     <= arb_gnt;
            timer   <= '0;
            m_start <= 1'b1;
            busy    <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          // master acknowledgement beats a simultaneous timeout
          if (m_busy) begin
            m_start <= 1'b0;
            timer   <= '0;
            state   <= XFER;
          end else if (timer == START_LAST) begin
            rsp_err[owner] <= 1'b1;
            m_start        <= 1'b0;
            timer          <= '0;
            state          <= spi_sched_pkg::GAP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        XFER: begin
          if (m_done) begin
            rsp_data         <= m_dout;
            rsp_valid[owner] <= 1'b1;
            timer            <= '0;
            state            <= spi_sched_pkg::GAP;
          end else if (timer == XFER_LAST) begin
            rsp_err[owner] <= 1'b1;
            timer          <= '0;
            state          <= spi_sched_pkg::GAP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        spi_sched_pkg::GAP: begin
          if (timer == GAP_LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_sched.sv
// Bench for spi_xfer_sched: transaction-timeline reference model, per-cycle compare,
// directed scenarios followed by randomized requests and master behaviour.
module tb_spi_xfer_sched;
  localparam int N = 4, DW = 8, ST = 64, XT = 512, GP = 16, NEVER = 100000;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  gnt, rsp_valid, rsp_err;
  logic [DW-1:0] rsp_data, m_din, m_dout;
  logic          busy, m_start, m_busy, m_done;

  spi_xfer_sched #(.N_REQ(N), .DW(DW), .START_TO(ST), .XFER_TO(XT), .GAP(GP)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data), .busy(busy),
    .m_start(m_start), .m_din(m_din), .m_busy(m_busy), .m_done(m_done), .m_dout(m_dout)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, n = 0;
  // current transaction as a timeline of absolute cycle numbers
  bit have_txn;
  int t_owner, t_s, t_x, t_e, t_mse, t_bd, t_dd, m_last;
  bit t_err;
  logic [7:0] t_din, t_dout, exp_rsp_data, exp_m_din;
  int plan_bd, plan_dd;
  logic [7:0] plan_dout;
  bit rand_en, hold_all;
  int gnt_log[$], gnt_cyc[$], ms_rise[$], ms_fall[$];
  int rv_cnt, err_cnt, last_rv, last_err, last_bfall;
  logic prev_ms, prev_busy;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, n, act, exp);
    end
  endtask

  task automatic note_fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s cycle=%0d wait bound expired", nm, n);
  endtask

  function automatic bit model_idle();
    return !have_txn || (n >= t_e + GP);
  endfunction

  // winner = requesting index at the smallest forward distance past last
  function automatic int rr_pick(input int last, input logic [N-1:0] r);
    int best = -1, bestd = N + 1, d;
    for (int i = 0; i < N; i++)
      if (r[i]) begin
        d = (i - last - 1 + N) % N;
        if (d < bestd) begin bestd = d; best = i; end
      end
    return best;
  endfunction

  task automatic model_reset();
    have_txn = 0; m_last = N - 1; exp_rsp_data = '0; exp_m_din = '0;
  endtask

  task automatic clear_logs();
    gnt_log.delete(); gnt_cyc.delete(); ms_rise.delete(); ms_fall.delete();
    rv_cnt = 0; err_cnt = 0; last_rv = -1; last_err = -1; last_bfall = -1;
  endtask

  task automatic plan_and_drive();
    int r, r2;
    if (have_txn && n == t_s && !hold_all) req[t_owner] = rand_en ? 1'($urandom_range(0, 1)) : 1'b0;
    if (rand_en)
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 7) == 0) begin
            req[i] = 1'b1;
            req_data[i*DW +: DW] = 8'($urandom);
          end
        end else if (!(have_txn && n == t_s && t_owner == i) && $urandom_range(0, 39) == 0) begin
          req[i] = 1'b0;
        end
      end
    if (model_idle() && req != '0) begin
      if (rand_en) begin
        r = $urandom_range(0, 19); r2 = $urandom_range(0, 19);
        plan_bd   = (r < 2) ? NEVER : (r == 2) ? ST - 1 : $urandom_range(0, 20);
        plan_dd   = (r2 < 2) ? NEVER : (r2 == 2) ? XT - 1 : (r2 == 3) ? XT - 2 : $urandom_range(0, 80);
        plan_dout = 8'($urandom);
      end
      have_txn = 1; t_owner = rr_pick(m_last, req); m_last = t_owner; t_s = n + 1;
      t_din = req_data[t_owner*DW +: DW]; t_bd = plan_bd; t_dd = plan_dd; t_dout = plan_dout;
      if (t_bd <= ST - 1) begin
        t_mse = t_s + t_bd; t_x = t_s + t_bd + 1;
        if (t_dd <= XT - 1) begin t_e = t_x + t_dd + 1; t_err = 0; end
        else begin t_e = t_x + XT; t_err = 1; end
      end else begin
        t_mse = t_s + ST - 1; t_x = -1; t_e = t_s + ST; t_err = 1;
      end
    end
    m_busy = have_txn && t_x >= 0 && n >= t_s + t_bd && n < t_e;
    m_done = 1'b0;
    m_dout = 8'($urandom);
    if (have_txn && t_x >= 0 && t_dd <= XT - 1 && n == t_x + t_dd) begin
      m_done = 1'b1; m_dout = t_dout;
    end else if ((!have_txn || t_x < 0 || n >= t_e) && rand_en && $urandom_range(0, 15) == 0) begin
      m_done = 1'b1;
    end
  endtask

  task automatic compare_now();
    logic [N-1:0] eg, erv, ere;
    logic ems, eb;
    eg = '0; erv = '0; ere = '0; ems = 1'b0; eb = 1'b0;
    if (have_txn) begin
      if (n == t_s) begin eg[t_owner] = 1'b1; exp_m_din = t_din; end
      ems = (n >= t_s) && (n <= t_mse);
      eb  = (n >= t_s) && (n < t_e + GP);
      if (n == t_e) begin
        if (t_err) ere[t_owner] = 1'b1;
        else begin erv[t_owner] = 1'b1; exp_rsp_data = t_dout; end
      end
    end
    check("gnt", gnt, eg);
    check("rsp_valid", rsp_valid, erv);
    check("rsp_err", rsp_err, ere);
    check("rsp_data", rsp_data, exp_rsp_data);
    check("m_din", m_din, exp_m_din);
    check("m_start", m_start, ems);
    check("busy", busy, eb);
    check("pulse_excl", $countones(gnt | rsp_valid | rsp_err) <= 1, 1);
    for (int i = 0; i < N; i++)
      if (gnt[i]) begin gnt_log.push_back(i); gnt_cyc.push_back(n); end
    if (|rsp_valid) begin rv_cnt++; last_rv = n; end
    if (|rsp_err) begin err_cnt++; last_err = n; end
    if (m_start && !prev_ms) ms_rise.push_back(n);
    if (!m_start && prev_ms) ms_fall.push_back(n);
    if (prev_busy && !busy) last_bfall = n;
    prev_ms = m_start; prev_busy = busy;
  endtask

  task automatic step();
    plan_and_drive();
    @(posedge clk);
    @(negedge clk);
    n++;
    compare_now();
  endtask

  task automatic run_until_idle(input int lim);
    int k = 0;
    while (!(model_idle() && req == '0) && k < lim) begin step(); k++; end
    if (k >= lim) note_fail("idle_wait");
  endtask

  task automatic wait_xfer(input int off, input int lim);
    int k = 0;
    while (!(gnt_log.size() >= 1 && have_txn && t_x >= 0 && n >= t_x + off) && k < lim) begin
      step(); k++;
    end
    if (k >= lim) note_fail("xfer_wait");
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; m_busy = 1'b0; m_done = 1'b0; m_dout = '0;
    repeat (2) begin @(posedge clk); @(negedge clk); n++; end
    model_reset();
    rst = 1'b0;
    prev_ms = 1'b0; prev_busy = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_m_start", m_start, 0);
    check("rst_pulses", gnt | rsp_valid | rsp_err, 0);
    check("rst_m_din", m_din, 0);
    check("rst_rsp_data", rsp_data, 0);
  endtask

  task automatic reset_mid();
    plan_and_drive();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_m_start", m_start, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_pulses", gnt | rsp_valid | rsp_err, 0);
    @(negedge clk);
    n++;
    model_reset();
    compare_now();
    rst = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog cycle=%0d simulation did not finish", n);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int k;
    rst = 1'b1; req = '0; req_data = '0; m_busy = 1'b0; m_done = 1'b0; m_dout = '0;
    rand_en = 0; hold_all = 0; plan_bd = 1; plan_dd = 5; plan_dout = 8'h00;
    do_reset();

    // single request with a slow echoing master
    clear_logs();
    req_data[2*DW +: DW] = 8'hA5; req[2] = 1'b1; k = n;
    plan_bd = 3; plan_dd = 66; plan_dout = 8'h3C;
    run_until_idle(400);
    check("t1_gnt_cnt", gnt_log.size(), 1);
    check("t1_gnt_idx", gnt_log[0], 2);
    check("t1_gnt_lat", gnt_cyc[0] - k, 1);
    check("t1_rsp_data", rsp_data, 8'h3C);
    check("t1_m_din", m_din, 8'hA5);
    check("t1_gap", last_bfall - last_rv, GP);

    // contention from reset, all held
    do_reset();
    clear_logs();
    req_data = 32'h44332211; req = 4'hF; hold_all = 1;
    plan_bd = 1; plan_dd = 10; plan_dout = 8'h77;
    k = 0;
    while (gnt_log.size() < 5 && k < 2000) begin step(); k++; end
    if (k >= 2000) note_fail("t2_grants");
    hold_all = 0; req = '0;
    run_until_idle(200);
    for (int i = 0; i < 5; i++) check("t2_order", gnt_log[i], exp_order[i]);
    for (int i = 1; i < 5; i++) check("t2_mstart_gap", (ms_rise[i] - ms_fall[i-1]) >= GP, 1);

    // start timeout
    clear_logs();
    req_data[1*DW +: DW] = 8'h11; req[1] = 1'b1;
    plan_bd = NEVER; plan_dd = 0;
    run_until_idle(300);
    check("t3_err_cnt", err_cnt, 1);
    check("t3_rv_cnt", rv_cnt, 0);
    check("t3_err_time", last_err - gnt_cyc[0], 64);
    check("t3_gap", last_bfall - last_err, 16);

    // m_done on the last allowed transfer cycle
    clear_logs();
    req_data[0 +: DW] = 8'h22; req[0] = 1'b1;
    plan_bd = 2; plan_dd = XT - 1; plan_dout = 8'h5A;
    run_until_idle(800);
    check("t4_rv_cnt", rv_cnt, 1);
    check("t4_err_cnt", err_cnt, 0);
    check("t4_rsp_data", rsp_data, 8'h5A);
    check("t4_rsp_time", last_rv - gnt_cyc[0], 515);

    // withdrawal of requester 1 during another transfer
    clear_logs();
    req_data[3*DW +: DW] = 8'h33; req[3] = 1'b1;
    plan_bd = 1; plan_dd = 40; plan_dout = 8'h44;
    wait_xfer(3, 200);
    req_data[1*DW +: DW] = 8'h55; req[1] = 1'b1;
    step();
    req[1] = 1'b0;
    run_until_idle(200);
    check("t5_gnt_cnt", gnt_log.size(), 1);
    check("t5_owner", gnt_log[0], 3);
    check("t5_rv_cnt", rv_cnt, 1);

    // asynchronous reset in the middle of a transfer
    clear_logs();
    req_data[2*DW +: DW] = 8'h66; req[2] = 1'b1;
    plan_bd = 1; plan_dd = 100; plan_dout = 8'h99;
    wait_xfer(5, 200);
    reset_mid();
    check("t6_no_rsp", rv_cnt + err_cnt, 0);
    clear_logs();
    req_data[3*DW +: DW] = 8'h77; req = 4'b1000;
    plan_bd = 1; plan_dd = 5; plan_dout = 8'h88;
    run_until_idle(300);
    check("t6_first_gnt", gnt_log[0], 3);
    check("t6_rsp_data", rsp_data, 8'h88);

    // randomized traffic
    clear_logs();
    rand_en = 1;
    k = 0;
    while (gnt_log.size() < 150 && k < 40000) begin step(); k++; end
    if (k >= 40000) note_fail("rand_grants");
    rand_en = 0; req = '0;
    run_until_idle(1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
